frame_generator: RTL and testbench
==================================

// Module: frame_generator
// PURPOSE
//  Free-running Ethernet test-frame source emitting 64-bit XGMII-style TX words (8 byte lanes + ctrl).
//  Drives the MAC/PCS-side TX interface of the verification agents; frames are synthetic (fixed header,
//  incrementing payload). Lane 0 = bits [7:0], transmitted first; o_tx_ctrl[n]=1 marks lane n as control.
// PARAMETERS
//  DATA_WIDTH   64                  TX data width; only 64 supported
//  CTRL_WIDTH   DATA_WIDTH/8        one ctrl bit per byte lane
//  PAYLOAD_LEN  46                  payload bytes after EtherType, 46..1500
//  DST_ADDR     48'hFFFF_FFFF_FFFF  destination MAC, MSB byte sent first
//  SRC_ADDR     48'h0011_2233_4455  source MAC, MSB byte sent first
//  ETHER_TYPE   16'h0800            EtherType, MSB byte sent first
//  IFG_CYCLES   2                   full idle words after the terminate word, min 1
// PORTS
//  clk          in   1           single clock, all logic on rising edge
//  i_rst        in   1           asynchronous, active-low reset
//  i_start      in   1           level: while high, frames repeat back-to-back (separated by IFG)
//  i_interrupt  in   8           bit0 abort, bit1 stop-after-frame, [7:2] reserved/ignored
//  o_tx_data    out  DATA_WIDTH  TX byte lanes
//  o_tx_ctrl    out  CTRL_WIDTH  TX lane control flags
// BEHAVIOUR
//  Codes: IDLE 8'h07, START 8'hFB, TERM 8'hFD, ERROR 8'hFE, preamble 8'h55, SFD 8'hD5.
//  Reset (i_rst=0): state IDLE, o_tx_data=64'h0707_0707_0707_0707, o_tx_ctrl=8'hFF, counters cleared.
//  Outputs registered; the word for state S is visible after the edge that enters S.
//  FSM: IDLE -> START -> DATA -> TERM -> IFG -> (IDLE | START).
//  IDLE: idle word. Go to START when i_start=1 and i_interrupt[1]=0; 1-cycle latency.
//  START: data 64'hD555_5555_5555_55FB, ctrl 8'h01.
//  DATA: byte stream = DST_ADDR, SRC_ADDR, ETHER_TYPE, payload bytes 0x00,0x01,... (mod 256), then FCS
//   when enabled. 8 bytes per word, ctrl 8'h00. A byte counter tracks position in the stream.
//  TERM: the first unused lane after the last frame byte gets FD (ctrl=1). Higher lanes get 07 (ctrl=1).
//   Earlier lanes carry the remaining data (ctrl=0). If the frame length is a multiple of 8, TERM is a
//   separate word 64'h0707_0707_0707_07FD with ctrl 8'hFF.
//  IFG: IFG_CYCLES idle words. Then START if i_start=1 and i_interrupt[1]=0, else IDLE.
//  i_start deasserted mid-frame: the current frame completes normally. It is sampled only in IDLE and at
//   the end of IFG.
//  i_interrupt[0] in START/DATA: the next word is all ERROR (64'hFEFE_FEFE_FEFE_FEFE, ctrl 8'hFF), then IFG.
//   No TERM is sent. Ignored in IDLE/IFG.
//  i_interrupt[1]: blocks new frames. If both bit0 and bit1 are set, abort takes priority.
//  Async reset mid-frame: immediately return to idle output.
// CONFIGURATION
//  FRAME_GEN_FCS_EN defined: a 4-byte IEEE 802.3 CRC-32 follows the payload, least-significant byte first.
//   Init 32'hFFFFFFFF, reflected, final complement. Covers DA..payload.
//   Default frame is 64 bytes -> 8 DATA words, then separate TERM word.
//  Undefined: no FCS. Default frame is 60 bytes -> TERM in lane 4.
// STRUCTURE
//  Package frame_gen_pkg: XGMII code constants, state enum typedef, IDLE_WORD/START_WORD localparams.
//  Sub-module crc32_d64 (only when FRAME_GEN_FCS_EN): combinational 64-bit-per-cycle CRC-32 with byte-valid
//   mask, used for the partial last word.
// TESTING
//  Reset held -> o_tx_data=64'h0707070707070707, o_tx_ctrl=8'hFF each cycle.
//  No FCS, defaults, i_start=1 -> START 64'hD555555555555 5FB/8'h01 (no space), then 64'h1100FFFFFFFFFFFF/8'h00,
//   64'h0100000855443322/8'h00; last word 64'h070707FD2D2C2B2A/8'hF0; then 2 idle words; next START.
//  FCS enabled, defaults -> 8 DATA words with ctrl 8'h00, FCS equals a software CRC-32 of the 60 bytes,
//   then 64'h07070707070707FD/8'hFF.
//  i_interrupt=8'h01 asserted during the 3rd DATA word -> next word 64'hFEFE...FE/8'hFF, then IFG idle words.
//  i_interrupt=8'h02 mid-frame with i_start=1 -> frame finishes with a normal TERM; output stays idle until
//   bit1 clears.
//  i_start pulsed one cycle -> exactly one frame, then idle indefinitely.

Source files
------------

// File: rtl/frame_gen_pkg.sv
// Shared XGMII code points, canned control words and the FSM state type for frame_generator.
package frame_gen_pkg;

   localparam logic [7:0] XGMII_IDLE     = 8'h07;
   localparam logic [7:0] XGMII_START    = 8'hFB;
   localparam logic [7:0] XGMII_TERM     = 8'hFD;
   localparam logic [7:0] XGMII_ERROR    = 8'hFE;
   localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
   localparam logic [7:0] XGMII_SFD      = 8'hD5;

   localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
   localparam logic [63:0] START_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
   localparam logic [63:0] ERROR_WORD = {8{XGMII_ERROR}};

   localparam logic [7:0] CTRL_ALL   = 8'hFF;
   localparam logic [7:0] CTRL_START = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_TERM,
      ST_IFG,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/frame_gen_crc32_d64.sv
// Combinational reflected CRC-32 (poly 0xEDB88320) over up to 8 byte lanes, lane 0 first.
module crc32_d64 (
   input  logic [31:0] i_crc,
   input  logic [63:0] i_data,
   input  logic [7:0]  i_valid,
   output logic [31:0] o_crc
);

   localparam logic [31:0] POLY = 32'hEDB8_8320;

   always_comb begin
      o_crc = i_crc;
      for (int l = 0; l < 8; l++) begin
         if (i_valid[l]) begin
            o_crc = o_crc ^ {24'h0, i_data[8*l +: 8]};
            for (int b = 0; b < 8; b++) begin
               o_crc = o_crc[0] ? ((o_crc >> 1) ^ POLY) : (o_crc >> 1);
            end
         end
      end
   end

endmodule

// File: rtl/frame_generator.sv
// Free-running synthetic Ethernet frame source on a 64-bit XGMII-style TX interface.
// Define FRAME_GEN_FCS_EN to append a CRC-32 FCS after the payload.
module frame_generator
   import frame_gen_pkg::*;
#(
   parameter int          DATA_WIDTH  = 64,
   parameter int          CTRL_WIDTH  = DATA_WIDTH / 8,
   parameter int          PAYLOAD_LEN = 46,
   parameter logic [47:0] DST_ADDR    = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_ADDR    = 48'h0011_2233_4455,
   parameter logic [15:0] ETHER_TYPE  = 16'h0800,
   parameter int          IFG_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [7:0]            i_interrupt,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic [CTRL_WIDTH-1:0] o_tx_ctrl
);

`ifdef FRAME_GEN_FCS_EN
   localparam int FCS_LEN = 4;
`else
   localparam int FCS_LEN = 0;
`endif
   localparam logic [15:0] DATA_LEN  = 16'(14 + PAYLOAD_LEN);
   localparam logic [15:0] FRAME_LEN = DATA_LEN + 16'(FCS_LEN);
   localparam logic [15:0] IFG_LEN   = 16'(IFG_CYCLES);

   state_t      state_q, state_d;
   logic [63:0] data_q, data_d;
   logic [7:0]  ctrl_q, ctrl_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [15:0] ifg_cnt_q, ifg_cnt_d;
   logic [63:0] raw_data, lane_data;
   logic [7:0]  data_mask, lane_ctrl;
   logic [15:0] remain;
   logic        launch, abort;
   logic        unused_int;

   assign unused_int = ^i_interrupt[7:2];
   assign launch     = i_start & ~i_interrupt[1];
   assign abort      = i_interrupt[0];
   assign remain     = FRAME_LEN - byte_cnt_q;

   // Header fields go out MSB byte first; payload is the byte offset past the EtherType.
   function automatic logic [7:0] byte_at(input logic [15:0] idx);
      logic [2:0] sel;
      byte_at = 8'h00;
      sel     = 3'd0;
      if (idx < 16'd6) begin
         sel     = 3'(16'd5 - idx);
         byte_at = DST_ADDR[{sel, 3'b000} +: 8];
      end else if (idx < 16'd12) begin
         sel     = 3'(16'd11 - idx);
         byte_at = SRC_ADDR[{sel, 3'b000} +: 8];
      end else if (idx < 16'd14) begin
         sel     = 3'(16'd13 - idx);
         byte_at = ETHER_TYPE[{sel[0], 3'b000} +: 8];
      end else begin
         byte_at = 8'(idx - 16'd14);
      end
   endfunction

   always_comb begin
      logic [15:0] idx;
      raw_data  = '0;
      data_mask = '0;
      for (int l = 0; l < 8; l++) begin
         idx = byte_cnt_q + 16'(l);
         if (idx < DATA_LEN) begin
            raw_data[8*l +: 8] = byte_at(idx);
            data_mask[l]       = 1'b1;
         end
      end
   end

`ifdef FRAME_GEN_FCS_EN
   logic [31:0] crc_q, crc_d, crc_word, fcs;

   // crc_word already folds in this word's data lanes, so FCS lanes in the same word see the full CRC.
   crc32_d64 u_crc (
      .i_crc   (crc_q),
      .i_data  (raw_data),
      .i_valid (data_mask),
      .o_crc   (crc_word)
   );
   assign fcs = ~crc_word;
`endif

   always_comb begin
      logic [15:0] idx;
      logic [1:0]  fcs_sel;
      lane_data = '0;
      lane_ctrl = '0;
      fcs_sel   = 2'd0;
      for (int l = 0; l < 8; l++) begin
         idx = byte_cnt_q + 16'(l);
         if (data_mask[l]) begin
            lane_data[8*l +: 8] = raw_data[8*l +: 8];
`ifdef FRAME_GEN_FCS_EN
         end else if (idx < FRAME_LEN) begin
            fcs_sel             = 2'(idx - DATA_LEN);
            lane_data[8*l +: 8] = fcs[{fcs_sel, 3'b000} +: 8];
`endif
         end else if (idx == FRAME_LEN) begin
            lane_data[8*l +: 8] = XGMII_TERM;
            lane_ctrl[l]        = 1'b1;
         end else begin
            lane_data[8*l +: 8] = XGMII_IDLE;
            lane_ctrl[l]        = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      data_d     = IDLE_WORD;
      ctrl_d     = CTRL_ALL;
      byte_cnt_d = byte_cnt_q;
      ifg_cnt_d  = ifg_cnt_q;
`ifdef FRAME_GEN_FCS_EN
      crc_d      = crc_q;
`endif
      case (state_q)
         ST_IDLE, ST_IFG: begin
            if (state_q == ST_IFG && ifg_cnt_q < IFG_LEN) begin
               ifg_cnt_d = ifg_cnt_q + 16'd1;
            end else if (launch) begin
               state_d    = ST_START;
               data_d     = START_WORD;
               ctrl_d     = CTRL_START;
               byte_cnt_d = 16'd0;
`ifdef FRAME_GEN_FCS_EN
               crc_d      = 32'hFFFF_FFFF;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START, ST_DATA: begin
            if (abort) begin
               state_d = ST_ERROR;
               data_d  = ERROR_WORD;
            end else begin
               // Exactly 8 bytes left still fills a DATA word; TERM then goes out alone.
               state_d    = (remain >= 16'd8) ? ST_DATA : ST_TERM;
               data_d     = lane_data;
               ctrl_d     = lane_ctrl;
               byte_cnt_d = byte_cnt_q + 16'd8;
`ifdef FRAME_GEN_FCS_EN
               crc_d      = crc_word;
`endif
            end
         end
         ST_TERM, ST_ERROR: begin
            state_d   = ST_IFG;
            ifg_cnt_d = 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= ST_IDLE;
         data_q     <= IDLE_WORD;
         ctrl_q     <= CTRL_ALL;
         byte_cnt_q <= 16'd0;
         ifg_cnt_q  <= 16'd0;
`ifdef FRAME_GEN_FCS_EN
         crc_q      <= 32'hFFFF_FFFF;
`endif
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         ctrl_q     <= ctrl_d;
         byte_cnt_q <= byte_cnt_d;
         ifg_cnt_q  <= ifg_cnt_d;
`ifdef FRAME_GEN_FCS_EN
         crc_q      <= crc_d;
`endif
      end
   end

   assign o_tx_data = data_q;
   assign o_tx_ctrl = ctrl_q;

endmodule

// File: tb/tb_frame_generator.sv
// Self-checking bench for frame_generator: expected TX words are queued as stimulus is driven
// and compared one cycle later when the DUT registers them.
module tb_frame_generator;

   localparam int PAYLOAD_LEN = 46;
   localparam int IFG_CYCLES  = 2;
   localparam int DATA_LEN    = 14 + PAYLOAD_LEN;
`ifdef FRAME_GEN_FCS_EN
   localparam int FCS_LEN = 4;
`else
   localparam int FCS_LEN = 0;
`endif
   localparam int FRAME_LEN = DATA_LEN + FCS_LEN;

   localparam logic [47:0] SA      = 48'h0011_2233_4455;
   localparam logic [71:0] W_IDLE  = {8'hFF, 64'h0707_0707_0707_0707};
   localparam logic [71:0] W_START = {8'h01, 64'hD555_5555_5555_55FB};
   localparam logic [71:0] W_ERROR = {8'hFF, 64'hFEFE_FEFE_FEFE_FEFE};

   logic        clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_interrupt = 8'h00;
   logic [63:0] o_tx_data;
   logic [7:0]  o_tx_ctrl;

   logic [71:0] exp_q[$];
   logic [71:0] frame_w[$];
   logic [7:0]  frame_b[FRAME_LEN];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   frame_generator dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_interrupt (i_interrupt),
      .o_tx_data   (o_tx_data),
      .o_tx_ctrl   (o_tx_ctrl)
   );

   task automatic check_word(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got ctrl/data=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] sw_crc32(input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, frame_b[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Reference frame: byte list first, then carved into START / DATA / TERM / IFG words.
   task automatic build_frame();
      logic [63:0] w;
      logic [7:0]  c;
      logic [31:0] crc;
      int          pos;
      int          rem;
      for (int i = 0; i < 6; i++) frame_b[i] = 8'hFF;
      for (int i = 0; i < 6; i++) frame_b[6+i] = SA[8*(5-i) +: 8];
      frame_b[12] = 8'h08;
      frame_b[13] = 8'h00;
      for (int i = 0; i < PAYLOAD_LEN; i++) frame_b[14+i] = 8'(i);
      crc = sw_crc32(DATA_LEN);
      for (int i = 0; i < FCS_LEN; i++) frame_b[DATA_LEN+i] = crc[8*i +: 8];
      frame_w.delete();
      frame_w.push_back(W_START);
      pos = 0;
      while (pos + 8 <= FRAME_LEN) begin
         for (int l = 0; l < 8; l++) w[8*l +: 8] = frame_b[pos+l];
         frame_w.push_back({8'h00, w});
         pos += 8;
      end
      rem = FRAME_LEN - pos;
      for (int l = 0; l < 8; l++) begin
         if (l < rem) begin
            w[8*l +: 8] = frame_b[pos+l];
            c[l] = 1'b0;
         end else begin
            w[8*l +: 8] = (l == rem) ? 8'hFD : 8'h07;
            c[l] = 1'b1;
         end
      end
      frame_w.push_back({c, w});
      for (int i = 0; i < IFG_CYCLES; i++) frame_w.push_back(W_IDLE);
   endtask

   task automatic drive_cycle(input logic s, input logic [7:0] intr, input logic [71:0] exp);
      @(negedge clk);
      i_start = s;
      i_interrupt = intr;
      exp_q.push_back(exp);
   endtask

   task automatic run_frame(input logic mid_start, input logic [7:0] mid_intr);
      for (int i = 0; i < frame_w.size(); i++)
         drive_cycle((i == 0) ? 1'b1 : mid_start, (i == 0) ? 8'h00 : mid_intr, frame_w[i]);
   endtask

   task automatic idle_cycles(input int n, input logic s, input logic [7:0] intr);
      for (int i = 0; i < n; i++) drive_cycle(s, intr, W_IDLE);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) check_word("tx_word", {o_tx_ctrl, o_tx_data}, exp_q.pop_front());
      end
   end

   initial begin
      logic [71:0] e;
      build_frame();

      repeat (3) begin
         @(negedge clk);
         check_word("reset_hold", {o_tx_ctrl, o_tx_data}, W_IDLE);
      end
      @(negedge clk);
      i_rst = 1'b1;
      idle_cycles(3, 1'b0, 8'h00);

      // Back-to-back frames with start held, then stop.
      run_frame(1'b1, 8'h00);
      run_frame(1'b1, 8'h00);
      idle_cycles(3, 1'b0, 8'h00);

      // Single-cycle start pulse: one frame, then idle; known words checked against literals.
      for (int i = 0; i < frame_w.size(); i++) begin
         e = frame_w[i];
`ifndef FRAME_GEN_FCS_EN
         if (i == 1) e = {8'h00, 64'h1100_FFFF_FFFF_FFFF};
         if (i == 2) e = {8'h00, 64'h0100_0008_5544_3322};
         if (i == 8) e = {8'hF0, 64'h0707_07FD_2D2C_2B2A};
`endif
         drive_cycle(i == 0, 8'h00, e);
      end
      idle_cycles(8, 1'b0, 8'h00);

      // Abort while the 3rd DATA word is on the wire; interrupt held through IFG is ignored.
      for (int i = 0; i < 4; i++) drive_cycle(i == 0, 8'h00, frame_w[i]);
      drive_cycle(1'b0, 8'h01, W_ERROR);
      idle_cycles(IFG_CYCLES, 1'b0, 8'h01);
      idle_cycles(2, 1'b0, 8'h00);

      // Abort in START with stop also set, then restart directly after IFG.
      drive_cycle(1'b1, 8'h00, W_START);
      drive_cycle(1'b1, 8'h03, W_ERROR);
      idle_cycles(IFG_CYCLES, 1'b1, 8'h00);
      run_frame(1'b0, 8'h00);
      idle_cycles(2, 1'b0, 8'h00);

      // Stop-after-frame mid-frame: frame completes, stays idle until bit1 clears.
      run_frame(1'b1, 8'h02);
      idle_cycles(5, 1'b1, 8'h02);
      run_frame(1'b0, 8'h00);
      idle_cycles(2, 1'b0, 8'h00);

      // Asynchronous reset mid-frame.
      for (int i = 0; i < 3; i++) drive_cycle(i == 0, 8'h00, frame_w[i]);
      @(negedge clk);
      i_rst = 1'b0;
      #1;
      check_word("async_reset", {o_tx_ctrl, o_tx_data}, W_IDLE);
      @(negedge clk);
      check_word("async_reset_hold", {o_tx_ctrl, o_tx_data}, W_IDLE);
      i_rst = 1'b1;
      run_frame(1'b0, 8'h00);
      idle_cycles(3, 1'b0, 8'h00);

      repeat (3) @(negedge clk);
      check_word("queue_drain", 72'(exp_q.size()), 72'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
